div_ctrl: RTL and testbench

Sequencing controller between the RV32M execute stage and the shared `division` datapath. Accepts DIV/DIVU/REM/REMU requests over a valid/ready handshake and resolves RISC-V special cases (divide-by-zero, signed overflow) without touching the datapath. For all other requests it runs the datapath twice on operand magnitudes, once for the quotient and once for the remainder, then applies sign correction. Both results are cached so that a DIV/REM pair on the same operands costs one datapath sequence.

---
 rtl/div_ctrl_if.sv | 35 +++
 rtl/div_ctrl.sv | 176 +++++++++++++++++
 tb/tb_div_ctrl.sv | 251 +++++++++++++++++++++++++
 3 files changed

// File: rtl/div_ctrl_if.sv
// ============================================================================
//  Module      : div_ctrl_if
//  Description : Request/response handshake bundle between the RV32M execute
//                stage (master) and the division sequencing controller (slave).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface div_ctrl_if #(
    parameter int LENGTH = 32
) ();
    logic              req_valid;
    logic              req_ready;
    logic [1:0]        req_op;
    logic [LENGTH-1:0] req_a;
    logic [LENGTH-1:0] req_b;
    logic [4:0]        req_tag;
    logic              resp_valid;
    logic              resp_ready;
    logic [LENGTH-1:0] resp_data;
    logic [4:0]        resp_tag;
    logic              resp_dz;

    modport master (
        output req_valid, req_op, req_a, req_b, req_tag, resp_ready,
        input  req_ready, resp_valid, resp_data, resp_tag, resp_dz
    );

    modport slave (
        input  req_valid, req_op, req_a, req_b, req_tag, resp_ready,
        output req_ready, resp_valid, resp_data, resp_tag, resp_dz
    );
endinterface

`default_nettype wire

// File: rtl/div_ctrl.sv
// ============================================================================
//  Module      : div_ctrl
//  Description : Sequences DIV/DIVU/REM/REMU through the shared division
//                datapath, filtering RISC-V special cases and caching q/r.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module div_ctrl #(
    parameter int LENGTH = 32
) (
    input  wire logic              clk,
    input  wire logic              rst,
    input  wire logic              flush,
    div_ctrl_if.slave              bus,
    output logic [LENGTH-1:0]      div_oper_a,
    output logic [LENGTH-1:0]      div_oper_b,
    output logic                   div_fuct3,
    output logic                   div_enable,
    input  wire logic [LENGTH-1:0] div_o,
    input  wire logic              div_finish,
    input  wire logic              divided_by_zero
);

    localparam logic [LENGTH-1:0] c_min  = {1'b1, {(LENGTH-1){1'b0}}};
    localparam logic [LENGTH-1:0] c_ones = '1;

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_ISSUE_Q = 3'd1,
        S_GAP     = 3'd2,
        S_ISSUE_R = 3'd3,
        S_FIX     = 3'd4,
        S_RESP    = 3'd5
    } state_t;

    state_t            r_state;
    state_t            w_next;

    logic              r_rst_hold;
    logic [LENGTH-1:0] r_a, r_b, r_q_raw, r_r_raw, r_res;
    logic              r_signed, r_rem, r_dz;
    logic [4:0]        r_tag;
    logic              r_c_valid, r_c_signed;
    logic [LENGTH-1:0] r_c_a, r_c_b, r_c_q, r_c_r;

    logic              w_accept, w_signed_in, w_dz, w_ovf, w_hit;
    logic [LENGTH-1:0] w_mag_a, w_mag_b, w_q, w_r;
    logic              w_unused_dbz;

    // The datapath's own zero flag is informational; b==0 never reaches it.
    assign w_unused_dbz = divided_by_zero;

    assign w_accept    = bus.req_valid && bus.req_ready;
    assign w_signed_in = ~bus.req_op[0];
    assign w_dz        = (bus.req_b == '0);
    assign w_ovf       = w_signed_in && (bus.req_a == c_min) && (bus.req_b == c_ones);
    assign w_hit       = r_c_valid && !flush && (r_c_a == bus.req_a) &&
                         (r_c_b == bus.req_b) && (r_c_signed == w_signed_in);

    assign w_mag_a = (r_signed && r_a[LENGTH-1]) ? -r_a : r_a;
    assign w_mag_b = (r_signed && r_b[LENGTH-1]) ? -r_b : r_b;
    assign w_q     = (r_signed && (r_a[LENGTH-1] ^ r_b[LENGTH-1])) ? -r_q_raw : r_q_raw;
    assign w_r     = (r_signed && r_a[LENGTH-1]) ? -r_r_raw : r_r_raw;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next         = r_state;
        bus.req_ready  = 1'b0;
        bus.resp_valid = 1'b0;
        div_enable     = 1'b0;
        div_fuct3      = 1'b0;
        div_oper_a     = '0;
        div_oper_b     = '0;
        case (r_state)
            S_IDLE: begin
                // Held low for one cycle after reset so the first accept
                // cannot race the reset release.
                bus.req_ready = !r_rst_hold;
                if (w_accept) begin
                    w_next = (w_dz || w_ovf || w_hit) ? S_RESP : S_ISSUE_Q;
                end
            end
            S_ISSUE_Q: begin
                div_enable = 1'b1;
                div_fuct3  = 1'b1;
                div_oper_a = w_mag_a;
                div_oper_b = w_mag_b;
                if (div_finish) w_next = S_GAP;
            end
            S_GAP:     w_next = S_ISSUE_R;
            S_ISSUE_R: begin
                div_enable = 1'b1;
                div_oper_a = w_mag_a;
                div_oper_b = w_mag_b;
                if (div_finish) w_next = S_FIX;
            end
            S_FIX:     w_next = S_RESP;
            S_RESP: begin
                bus.resp_valid = 1'b1;
                if (bus.resp_ready) w_next = S_IDLE;
            end
            default:   w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_rst_hold <= 1'b1;
            r_c_valid  <= 1'b0;
            r_res      <= '0;
            r_tag      <= '0;
            r_dz       <= 1'b0;
            r_a        <= '0;
            r_b        <= '0;
            r_signed   <= 1'b0;
            r_rem      <= 1'b0;
            r_q_raw    <= '0;
            r_r_raw    <= '0;
            r_c_signed <= 1'b0;
            r_c_a      <= '0;
            r_c_b      <= '0;
            r_c_q      <= '0;
            r_c_r      <= '0;
        end else begin
            r_rst_hold <= 1'b0;
            if (flush) r_c_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_a      <= bus.req_a;
                        r_b      <= bus.req_b;
                        r_signed <= w_signed_in;
                        r_rem    <= bus.req_op[1];
                        r_tag    <= bus.req_tag;
                        r_dz     <= w_dz;
                        if (w_dz) begin
                            r_res <= bus.req_op[1] ? bus.req_a : c_ones;
                        end else if (w_ovf) begin
                            r_res <= bus.req_op[1] ? '0 : c_min;
                        end else if (w_hit) begin
                            r_res <= bus.req_op[1] ? r_c_r : r_c_q;
                        end
                    end
                end
                S_ISSUE_Q: if (div_finish) r_q_raw <= div_o;
                S_ISSUE_R: if (div_finish) r_r_raw <= div_o;
                S_FIX: begin
                    // Placed after the flush clear so a same-cycle write wins.
                    r_c_valid  <= 1'b1;
                    r_c_a      <= r_a;
                    r_c_b      <= r_b;
                    r_c_signed <= r_signed;
                    r_c_q      <= w_q;
                    r_c_r      <= w_r;
                    r_res      <= r_rem ? w_r : w_q;
                end
                default: ;
            endcase
        end
    end

    assign bus.resp_data = r_res;
    assign bus.resp_tag  = r_tag;
    assign bus.resp_dz   = r_dz;

endmodule

`default_nettype wire

// File: tb/tb_div_ctrl.sv
// ============================================================================
//  Module      : tb_div_ctrl
//  Description : Self-checking bench for div_ctrl with a latency-programmable
//                datapath model and a behavioural RV32M/cache reference.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_div_ctrl;

    localparam logic [31:0] c_min  = 32'h8000_0000;
    localparam logic [31:0] c_ones = 32'hFFFF_FFFF;
    localparam logic [1:0]  c_div  = 2'b00;
    localparam logic [1:0]  c_divu = 2'b01;
    localparam logic [1:0]  c_rem  = 2'b10;
    localparam logic [1:0]  c_remu = 2'b11;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic [31:0] div_oper_a, div_oper_b, div_o;
    logic        div_fuct3, div_enable, div_finish, divided_by_zero;

    int n_tests = 0;
    int n_fail  = 0;

    int dp_lat = 1;
    int dp_cnt = 0;

    logic        ref_c_valid = 1'b0;
    logic [31:0] ref_c_a, ref_c_b;
    logic        ref_c_s;

    div_ctrl_if #(.LENGTH(32)) bus ();

    div_ctrl #(.LENGTH(32)) dut (
        .clk            (clk),
        .rst            (rst),
        .flush          (flush),
        .bus            (bus.slave),
        .div_oper_a     (div_oper_a),
        .div_oper_b     (div_oper_b),
        .div_fuct3      (div_fuct3),
        .div_enable     (div_enable),
        .div_o          (div_o),
        .div_finish     (div_finish),
        .divided_by_zero(divided_by_zero)
    );

    always #5 clk = ~clk;

    // Datapath model: result offered in the dp_lat-th consecutive enable cycle.
    always_comb begin
        div_finish      = div_enable && (dp_cnt == dp_lat - 1);
        divided_by_zero = div_enable && (div_oper_b == 32'd0);
        if (div_oper_b == 32'd0) div_o = c_ones;
        else                     div_o = div_fuct3 ? (div_oper_a / div_oper_b) : (div_oper_a % div_oper_b);
    end

    always @(posedge clk) begin
        if (!div_enable || div_finish) dp_cnt <= 0;
        else                           dp_cnt <= dp_cnt + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] ref_res(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b);
        logic signed [31:0] sa, sb, sq, sr;
        sa = a;
        sb = b;
        if (b == 32'd0) return op[1] ? a : c_ones;
        if (!op[0]) begin
            if (a == c_min && b == c_ones) return op[1] ? 32'd0 : c_min;
            sq = sa / sb;
            sr = sa % sb;
            return op[1] ? sr : sq;
        end
        return op[1] ? (a % b) : (a / b);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_req(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] tag, input int lat, input logic fl, input int bp);
        logic        sgn, special, hit, prev_en;
        logic [31:0] exp_data, mag_a, mag_b;
        int          exp_lat, cyc, en_cyc, rises, bad_ctl, bad_hold, dbz, w;

        sgn      = ~op[0];
        special  = (b == 32'd0) || (sgn && a == c_min && b == c_ones);
        if (fl) ref_c_valid = 1'b0;
        hit      = !special && ref_c_valid && ref_c_a == a && ref_c_b == b && ref_c_s == sgn;
        exp_data = ref_res(op, a, b);
        exp_lat  = (special || hit) ? 1 : 2 * lat + 3;
        mag_a    = (sgn && a[31]) ? -a : a;
        mag_b    = (sgn && b[31]) ? -b : b;
        dp_lat   = lat;

        w = 0;
        while (!bus.req_ready && w < 50) begin tick(); w++; end
        if (!bus.req_ready) begin check("ready_wait", 32'd0, 32'd1); return; end

        bus.req_valid  = 1'b1;
        bus.req_op     = op;
        bus.req_a      = a;
        bus.req_b      = b;
        bus.req_tag    = tag;
        bus.resp_ready = (bp == 0);
        flush          = fl;
        tick();
        bus.req_valid = 1'b0;
        flush         = 1'b0;

        cyc = 1; en_cyc = 0; rises = 0; bad_ctl = 0; dbz = 0; prev_en = 1'b0;
        while (!bus.resp_valid && cyc < 200) begin
            if (div_enable) begin
                en_cyc++;
                if (!prev_en) rises++;
                if (div_oper_a !== mag_a || div_oper_b !== mag_b || div_fuct3 !== (rises == 1)) bad_ctl++;
            end else if (div_oper_a !== 32'd0 || div_oper_b !== 32'd0 || div_fuct3 !== 1'b0) begin
                bad_ctl++;
            end
            if (bus.req_ready) bad_ctl++;
            if (divided_by_zero) dbz++;
            prev_en = div_enable;
            tick();
            cyc++;
        end
        if (!bus.resp_valid) begin check("timeout", 32'd0, 32'd1); return; end

        check("latency",   cyc, exp_lat);
        check("resp_data", bus.resp_data, exp_data);
        check("resp_tag",  {27'd0, bus.resp_tag}, {27'd0, tag});
        check("resp_dz",   {31'd0, bus.resp_dz}, {31'd0, b == 32'd0});
        check("en_cycles", en_cyc, (special || hit) ? 0 : 2 * lat);
        check("en_bursts", rises, (special || hit) ? 0 : 2);
        check("issue_ctl", bad_ctl, 0);
        check("dp_dbz",    dbz, 0);

        if (bp > 0) begin
            bad_hold = 0;
            repeat (bp) begin
                tick();
                if (!bus.resp_valid || bus.resp_data !== exp_data || bus.resp_tag !== tag || bus.req_ready)
                    bad_hold++;
            end
            check("bp_hold", bad_hold, 0);
            bus.resp_ready = 1'b1;
        end
        tick();
        check("post_idle", {30'd0, bus.resp_valid, bus.req_ready}, 32'd1);

        if (!special && !hit) begin
            ref_c_valid = 1'b1;
            ref_c_a     = a;
            ref_c_b     = b;
            ref_c_s     = sgn;
        end
    endtask

    initial begin
        logic [31:0] ra, rb, pa, pb;
        logic [1:0]  rop;
        int          kind;

        bus.req_valid  = 1'b0;
        bus.req_op     = 2'b00;
        bus.req_a      = 32'd0;
        bus.req_b      = 32'd0;
        bus.req_tag    = 5'd0;
        bus.resp_ready = 1'b1;
        rst            = 1'b1;
        repeat (2) tick();
        check("rst_outs", {27'd0, bus.req_ready, bus.resp_valid, div_enable, div_fuct3, bus.resp_dz}, 32'd0);
        check("rst_data", bus.resp_data | div_oper_a | div_oper_b | {27'd0, bus.resp_tag}, 32'd0);
        rst = 1'b0;
        tick();
        check("rst_release_ready", {31'd0, bus.req_ready}, 32'd1);

        do_req(c_div,  32'hFFFF_FFF9, 32'd3, 5'd1, 1, 1'b0, 0);
        do_req(c_rem,  32'hFFFF_FFF9, 32'd3, 5'd2, 1, 1'b0, 0);
        do_req(c_divu, 32'd7, 32'd0, 5'd3, 1, 1'b0, 0);
        do_req(c_remu, 32'd7, 32'd0, 5'd4, 1, 1'b0, 0);
        do_req(c_div,  c_min, c_ones, 5'd5, 1, 1'b0, 0);
        do_req(c_rem,  c_min, c_ones, 5'd6, 1, 1'b0, 0);
        do_req(c_divu, 32'd3025, 32'd12, 5'd7, 1, 1'b0, 0);
        do_req(c_remu, 32'd3025, 32'd12, 5'd8, 1, 1'b0, 0);
        do_req(c_div,  32'd18, 32'd6, 5'd9, 4, 1'b0, 3);
        do_req(c_rem,  32'd18, 32'd6, 5'd10, 4, 1'b1, 0);

        // Reset while the quotient run is in flight.
        dp_lat = 4;
        bus.req_valid = 1'b1;
        bus.req_op    = c_div;
        bus.req_a     = 32'd100;
        bus.req_b     = 32'd7;
        bus.req_tag   = 5'd11;
        tick();
        bus.req_valid = 1'b0;
        check("in_issue_q", {31'd0, div_enable}, 32'd1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_outs", {29'd0, div_enable, bus.resp_valid, bus.req_ready}, 32'd0);
        tick();
        check("abort_ready", {31'd0, bus.req_ready}, 32'd1);
        ref_c_valid = 1'b0;
        do_req(c_div, 32'd100, 32'd7, 5'd12, 1, 1'b0, 0);
        do_req(c_rem, 32'd100, 32'd7, 5'd13, 1, 1'b0, 0);

        pa = 32'd50;
        pb = 32'd9;
        for (int i = 0; i < 40; i++) begin
            kind = $urandom_range(0, 6);
            rop  = 2'($urandom_range(0, 3));
            ra   = $urandom;
            rb   = ($urandom_range(0, 1) == 1) ? 32'($urandom_range(1, 40)) : $urandom;
            case (kind)
                0: rb = 32'd0;
                1: begin ra = c_min; rb = c_ones; end
                2, 3: begin ra = pa; rb = pb; end
                default: ;
            endcase
            do_req(rop, ra, rb, 5'($urandom_range(0, 31)), $urandom_range(1, 3),
                   ($urandom_range(0, 7) == 0), $urandom_range(0, 2));
            pa = ra;
            pb = rb;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
